// File: rtl/pad_debounce_pkg.sv
// Shared types and width helper for the pad input debouncer.
// Each board input has its own copy of the debounce FSM.
package pad_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_e;

  // The counter only has to hold values up to DEBOUNCE_CYCLES-1.
  function automatic int cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pad_input_debouncer_if.sv
// Raw/debounced pad signal bundle, W channels wide.
interface pad_input_debouncer_if #(
  parameter int W = 1
);
  logic [W-1:0] raw;
  logic [W-1:0] level;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  modport master (output raw, input level, input rise, input fall);
  modport slave  (input raw, output level, output rise, output fall);
endinterface

// File: rtl/debounce_channel.sv
// Single-channel debouncer: 2-flop synchronizer, stability FSM with run
// counter, and registered level/edge outputs.
module debounce_channel
  import pad_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  pad_input_debouncer_if.slave    ch
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= ch.raw[0];
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: if (sync2_q) begin
        state_d = WAIT_HI;
        cnt_d   = CNT_W'(1);
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: if (!sync2_q) begin
        state_d = WAIT_LO;
        cnt_d   = CNT_W'(1);
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    // Output level is the accepted level of the FSM, registered once more
    // so the edge pulses line up with the first cycle of the new level.
    level_d = (state_q == STABLE_HI) || (state_q == WAIT_LO);
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
  end

  assign ch.level = level_q;
  assign ch.rise  = rise_q;
  assign ch.fall  = fall_q;

endmodule

// File: rtl/pad_input_debouncer.sv
// Board button/switch conditioner: one independent debounce channel per input.
module pad_input_debouncer
  import pad_debounce_pkg::*;
#(
  parameter int NUM_INPUTS      = 7,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  ref_clk_i,
  input  logic                  pad_reset,
  input  logic [NUM_INPUTS-1:0] raw_i,
  output logic [NUM_INPUTS-1:0] level_o,
  output logic [NUM_INPUTS-1:0] rise_o,
  output logic [NUM_INPUTS-1:0] fall_o
);

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_ch
    pad_input_debouncer_if #(.W(1)) ch_if ();

    assign ch_if.raw  = raw_i[k];
    assign level_o[k] = ch_if.level[0];
    assign rise_o[k]  = ch_if.rise[0];
    assign fall_o[k]  = ch_if.fall[0];

    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk (ref_clk_i),
      .rst (pad_reset),
      .ch  (ch_if)
    );
  end

endmodule

// File: tb/tb_pad_input_debouncer.sv
// Scoreboard bench: run-length reference model predicts level/rise/fall each cycle.
module tb_pad_input_debouncer;

  localparam int N = 7;
  localparam int D = 4;

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  pad_input_debouncer_if #(.W(N)) bus ();

  always #5 clk = ~clk;

  pad_input_debouncer #(
    .NUM_INPUTS      (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .ref_clk_i (clk),
    .pad_reset (rst),
    .raw_i     (bus.raw),
    .level_o   (bus.level),
    .rise_o    (bus.rise),
    .fall_o    (bus.fall)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a level is accepted once D consecutive synchronized
  // samples differ from it; samples reach the filter 2 edges late and the
  // accepted level shows on the outputs one edge after acceptance.
  int   run  [N];
  logic acc  [N];
  logic d1   [N];
  logic d2   [N];
  logic olvl [N];

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      run[k] = 0; acc[k] = 1'b0; d1[k] = 1'b0; d2[k] = 1'b0; olvl[k] = 1'b0;
    end
  endfunction

  function automatic exp_t model_step(input logic [N-1:0] r);
    exp_t e;
    logic s, nl;
    e = '0;
    for (int k = 0; k < N; k++) begin
      s     = d2[k];
      d2[k] = d1[k];
      d1[k] = r[k];
      nl    = acc[k];
      if (s != acc[k]) begin
        run[k]++;
        if (run[k] == D) begin
          acc[k] = s;
          run[k] = 0;
        end
      end else begin
        run[k] = 0;
      end
      e.lvl[k]  = nl;
      e.rise[k] = nl & ~olvl[k];
      e.fall[k] = ~nl & olvl[k];
      olvl[k]   = nl;
    end
    return e;
  endfunction

  task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check_vec("level", bus.level, e.lvl);
        check_vec("rise",  bus.rise,  e.rise);
        check_vec("fall",  bus.fall,  e.fall);
      end
    end
  end

  task automatic drive(input logic [N-1:0] r);
    bus.raw = r;
    @(posedge clk);
    if (rst) begin
      model_reset();
      q.push_back('0);
    end else begin
      q.push_back(model_step(r));
    end
    #1;
  endtask

  task automatic hold(input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) drive(r);
  endtask

  task automatic pulse_reset(input logic [N-1:0] r, input int n);
    rst = 1'b1;
    #1;
    check_vec("async_rst_level", bus.level, '0);
    check_vec("async_rst_rise",  bus.rise,  '0);
    check_vec("async_rst_fall",  bus.fall,  '0);
    q.delete();
    q.push_back('0);
    model_reset();
    hold(r, n);
    rst = 1'b0;
  endtask

  task automatic measure(input int b, input logic want, input logic [N-1:0] r, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      drive(r);
      if (lat < 0 && bus.level[b] === want) lat = i;
    end
  endtask

  initial begin
    int lat;
    logic [N-1:0] cur, flip;
    model_reset();
    rst = 1'b1;
    bus.raw = '0;
    #1;
    check_vec("reset_level", bus.level, '0);
    check_vec("reset_rise",  bus.rise,  '0);
    check_vec("reset_fall",  bus.fall,  '0);
    hold('0, 2);
    rst = 1'b0;
    hold('0, 3);

    // Single-channel accept latency.
    measure(0, 1'b1, 7'h01, lat);
    check_int("rise0_latency", lat, D + 2);
    hold('0, 10);

    // Short high pulse is rejected.
    hold(7'h02, 3);
    hold('0, 12);

    // Accept high then accept low.
    hold(7'h04, 10);
    measure(2, 1'b0, '0, lat);
    check_int("fall2_latency", lat, D + 2);

    // Chatter faster than the filter.
    for (int i = 0; i < 20; i++) hold((i % 2) ? 7'h00 : 7'h08, 2);
    hold('0, 10);

    // All channels at once.
    hold(7'h7F, 10);
    hold('0, 10);

    // Reset during a pending rise on channel 4, with other channels already high.
    hold(7'h6F, 10);
    hold(7'h7F, 4);
    pulse_reset(7'h7F, 2);
    measure(4, 1'b1, 7'h7F, lat);
    check_int("rst_release_latency", lat, D + 2);

    // Randomized chatter with occasional resets.
    cur = 7'h7F;
    for (int i = 0; i < 2000; i++) begin
      flip = N'($urandom) & N'($urandom);
      if (((i / 200) % 2) == 1) flip &= N'($urandom);
      cur ^= flip;
      if ($urandom_range(0, 299) == 0) pulse_reset(cur, 1);
      else drive(cur);
    end
    hold(cur, 10);

    @(negedge clk);
    #1;
    check_int("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pad_input_debouncer.md
PAD_INPUT_DEBOUNCER -- requirements
Module: pad_input_debouncer

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 7, giving the number of board inputs conditioned (3 buttons + 4 switches).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the number of consecutive stable cycles required to accept a new level; legal range 2..2^24-1.
REQ-003 The block SHALL have port ref_clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port pad_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port raw_i, input, NUM_INPUTS bits: asynchronous raw button/switch levels from the board pins.
REQ-006 The block SHALL have port level_o, output, NUM_INPUTS bits: the debounced level per channel, driven towards the SoC GPIO pads.
REQ-007 The block SHALL have port rise_o, output, NUM_INPUTS bits: a one-cycle pulse per channel on an accepted 0->1 transition.
REQ-008 The block SHALL have port fall_o, output, NUM_INPUTS bits: a one-cycle pulse per channel on an accepted 1->0 transition.

Function
REQ-009 Each channel SHALL pass raw_i[k] through a 2-flop synchronizer; sync[k] is the second flop output.
REQ-010 Each channel SHALL run an FSM with states STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO.
REQ-011 In STABLE_LO with sync=1, the channel SHALL go to WAIT_HI with counter=1; in STABLE_HI with sync=0, it SHALL go to WAIT_LO with counter=1.
REQ-012 In WAIT_HI/WAIT_LO, if sync still differs from the stable level, the counter SHALL increment.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and sync still differs, the next edge SHALL enter STABLE_HI/STABLE_LO respectively, toggle level_o[k] and clear the counter.
REQ-014 In WAIT_HI/WAIT_LO, if sync returns to the stable level, the channel SHALL go back to STABLE_LO/STABLE_HI, clear the counter, and leave level_o unchanged; glitches of fewer than DEBOUNCE_CYCLES cycles are rejected.
REQ-015 level_o[k] SHALL change exactly DEBOUNCE_CYCLES+2 rising edges after the edge that first samples a stable new raw level, covering 2 synchronizer stages and DEBOUNCE_CYCLES filter cycles.
REQ-016 rise_o[k]/fall_o[k] SHALL be registered and asserted in the same cycle that level_o[k] first shows the new value, for exactly one cycle; rise_o[k] and fall_o[k] are never both 1.
REQ-017 The counter SHALL be CNT_W = $clog2(DEBOUNCE_CYCLES) bits and SHALL never wrap, since it is cleared at the accept or abort point.
REQ-018 Channels SHALL be fully independent, so simultaneous transitions on several channels each complete on their own schedule.

Reset
REQ-019 On pad_reset=1, asynchronously: synchronizer flops SHALL be 0, FSM SHALL be STABLE_LO, counter SHALL be 0, and level_o, rise_o and fall_o SHALL be 0.
REQ-020 Reset asserted mid-WAIT SHALL abandon the pending transition and emit no pulse; after release, an input held high SHALL be accepted after a full DEBOUNCE_CYCLES+2 cycles.
REQ-021 Reset release needs no synchronization inside this block; the top level provides a release synchronized to ref_clk_i.

Structure
REQ-022 The FSM state enum (2 bits) and the CNT_W derivation function SHALL live in package pad_debounce_pkg.
REQ-023 Per-channel logic (synchronizer, FSM, counter, pulse registers) SHALL be sub-module debounce_channel, instantiated NUM_INPUTS times via generate.
REQ-024 The top level SHALL contain no logic beyond the generate loop and port slicing.

Verification (DEBOUNCE_CYCLES=4, NUM_INPUTS=7)
REQ-025 Directed test: raw_i[0] 0->1 held -> level_o[0]=1 and rise_o[0]=1 for one cycle exactly 6 edges after the first sampling edge; other bits stay 0.
REQ-026 Directed test: raw_i[1] high pulse of 3 cycles, then low -> level_o[1] stays 0, no rise_o/fall_o.
REQ-027 Directed test: accepted high on raw_i[2], then low held -> fall_o[2] one-cycle pulse and level_o[2]=0 6 edges after the falling sample.
REQ-028 Directed test: raw_i[3] toggling every 2 cycles for 40 cycles -> no level change, counter never exceeds 2.
REQ-029 Directed test: raw_i[4] high, pad_reset pulsed at counter=2 -> all outputs 0 immediately; level_o[4]=1 6 edges after release.
REQ-030 Directed test: raw_i = 7'h7F at once -> level_o goes from 0 to 7'h7F in a single cycle, rise_o=7'h7F for one cycle.
